seg7_monitor: RTL and testbench

Receive-side checker for the single-digit seven-segment counter output. Samples the 7-bit active-low segment bus, waits until a pattern is stable, decodes it back to a BCD digit, and checks that successive digits follow the 0→9→0 counting sequence. Used on-board as a self-check tap and in benches as the scoreboard front end for the display counter.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_monitor_if.sv | 25 ++
 rtl/seg7_decode.sv | 35 +++
 rtl/seg7_monitor.sv | 126 ++++++++++++
 tb/tb_seg7_monitor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment codes and monitor state type
package seg7_pkg;

    // Active-low segment codes, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } mon_state_t;

endpackage

// File: rtl/seg7_monitor_if.sv
// rtl/seg7_monitor_if.sv - segment bus and monitor result signals
interface seg7_monitor_if #(
    parameter int ERR_W = 8
);
    logic [6:0]       seg;
    logic [3:0]       digit;
    logic             digit_valid;
    logic             blank;
    logic             invalid;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;
    logic             locked;

    // master drives the segment bus and observes results
    modport master (
        output seg,
        input  digit, digit_valid, blank, invalid, seq_err, err_cnt, locked
    );

    // slave is the monitor itself
    modport slave (
        input  seg,
        output digit, digit_valid, blank, invalid, seq_err, err_cnt, locked
    );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low pattern to digit lookup
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       is_blank_o,
    output logic       is_valid_o
);

    // table lookup; anything outside the eleven known codes is invalid
    always_comb begin
        digit_o    = 4'd0;
        is_blank_o = 1'b0;
        is_valid_o = 1'b1;
        case (seg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: begin
                is_blank_o = 1'b1;
                is_valid_o = 1'b0;
            end
            default:   is_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// rtl/seg7_monitor.sv - stability filter, decode and 0-9 sequence checker
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seg7_monitor_if.slave bus
);

    localparam int                STAB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

    logic [6:0]        seg_q;
    logic [STAB_W-1:0] stab_q;
    logic              accepted_q;
    logic              accept;

    mon_state_t        state_q, state_d;
    logic [3:0]        digit_q, digit_d;
    logic              blank_q, blank_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              digit_valid_q, digit_valid_d;
    logic              invalid_q, invalid_d;
    logic              seq_err_q, seq_err_d;

    logic [3:0]        dec_digit;
    logic              dec_blank;
    logic              dec_valid;
    logic [3:0]        next_expected;
    logic              bump;

    // the pattern counts as settled once it has sat in seg_q long enough
    assign accept = (stab_q == STAB_MAX) && !accepted_q;

    seg7_decode u_decode (
        .seg_i      (seg_q),
        .digit_o    (dec_digit),
        .is_blank_o (dec_blank),
        .is_valid_o (dec_valid)
    );

    // input register plus stability counter; a change restarts qualification
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q      <= SEG_BLANK;
            stab_q     <= '0;
            accepted_q <= 1'b0;
        end else begin
            seg_q <= bus.seg;
            if (bus.seg != seg_q) begin
                stab_q     <= '0;
                accepted_q <= 1'b0;
            end else begin
                if (stab_q != STAB_MAX) stab_q <= stab_q + STAB_W'(1);
                if (accept) accepted_q <= 1'b1;
            end
        end
    end

    // lock/sequence FSM acting only on accepted patterns
    always_comb begin
        state_d       = state_q;
        digit_d       = digit_q;
        blank_d       = blank_q;
        err_cnt_d     = err_cnt_q;
        digit_valid_d = 1'b0;
        invalid_d     = 1'b0;
        seq_err_d     = 1'b0;
        bump          = 1'b0;
        next_expected = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        if (accept) begin
            if (dec_blank) begin
                // blank means the counter restarted; the next digit resyncs
                blank_d = 1'b1;
                state_d = UNLOCKED;
            end else if (dec_valid) begin
                blank_d       = 1'b0;
                digit_valid_d = 1'b1;
                digit_d       = dec_digit;
                state_d       = LOCKED;
                if (state_q == LOCKED && dec_digit != next_expected) begin
                    seq_err_d = 1'b1;
                    bump      = 1'b1;
                end
            end else begin
                blank_d   = 1'b0;
                invalid_d = 1'b1;
                bump      = 1'b1;
            end
        end
        if (bump && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    // registered outputs and FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= UNLOCKED;
            digit_q       <= 4'd0;
            blank_q       <= 1'b0;
            err_cnt_q     <= '0;
            digit_valid_q <= 1'b0;
            invalid_q     <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            blank_q       <= blank_d;
            err_cnt_q     <= err_cnt_d;
            digit_valid_q <= digit_valid_d;
            invalid_q     <= invalid_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.blank       = blank_q;
    assign bus.invalid     = invalid_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_seg7_monitor.sv
// tb/tb_seg7_monitor.sv - scoreboard bench for seg7_monitor
module tb_seg7_monitor;

    localparam int S  = 4;
    localparam int EW = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_monitor_if #(.ERR_W(EW)) bus ();

    seg7_monitor #(.STABLE_CYCLES(S), .ERR_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int t;
        bit dv;
        bit inv;
        bit blk;
        int digit;
        bit seq;
        int err;
        bit locked;
    } exp_t;

    exp_t       q[$];
    logic [6:0] font [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    // reference state: what a human watching the display would conclude
    int         m_last, m_err;
    bit         m_locked, m_blank;
    logic [6:0] prev_seg;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    // 0..9 for a digit, 10 for blank, -1 for anything else
    function automatic int ref_decode(logic [6:0] p);
        if (p == 7'h7F) return 10;
        for (int i = 0; i < 10; i++) if (font[i] == p) return i;
        return -1;
    endfunction

    function automatic void ref_accept(logic [6:0] p, int t);
        exp_t e;
        int   d;
        d = ref_decode(p);
        e.t = t; e.dv = 0; e.inv = 0; e.blk = 0; e.seq = 0;
        if (d == 10) begin
            m_locked = 0;
            if (!m_blank) begin
                e.blk = 1;
                e.digit = m_last; e.err = m_err; e.locked = 0;
                q.push_back(e);
            end
            m_blank = 1;
        end else if (d >= 0) begin
            e.seq = m_locked && (d != (m_last + 1) % 10);
            if (e.seq && m_err < ERR_MAX) m_err++;
            m_last = d; m_locked = 1; m_blank = 0;
            e.dv = 1; e.digit = d; e.err = m_err; e.locked = 1;
            q.push_back(e);
        end else begin
            if (m_err < ERR_MAX) m_err++;
            m_blank = 0;
            e.inv = 1; e.digit = m_last; e.err = m_err; e.locked = m_locked;
            q.push_back(e);
        end
    endfunction

    // present p for n cycles; it qualifies only when held at least S cycles
    task automatic drive(input logic [6:0] p, input int n);
        @(negedge clk);
        bus.seg = p;
        if (p != prev_seg && n >= S) ref_accept(p, cyc + 1 + S);
        prev_seg = p;
        repeat (n - 1) @(negedge clk);
    endtask

    // one reset edge with seg left as it is, then hold for n cycles
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_digit", bus.digit, 0);
        chk("rst_blank", bus.blank, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_pulses", {bus.digit_valid, bus.invalid, bus.seq_err}, 0);
        chk("rst_queue_drained", q.size(), 0);
        rst_n = 1'b1;
        m_last = 0; m_err = 0; m_locked = 0; m_blank = 0;
        if (bus.seg == 7'h7F) ref_accept(bus.seg, cyc + S);
        else                  ref_accept(bus.seg, cyc + 1 + S);
        prev_seg = bus.seg;
        repeat (n - 1) @(negedge clk);
    endtask

    // monitor: every pulse or blank rise must match the head of the queue
    initial begin : monitor
        exp_t e;
        bit   blank_prev;
        bit   ev;
        blank_prev = 0;
        forever begin
            @(negedge clk);
            ev = (bus.digit_valid === 1'b1) || (bus.invalid === 1'b1) ||
                 ((bus.blank === 1'b1) && !blank_prev);
            if (ev) begin
                if (q.size() > 0 && q[0].t == cyc) begin
                    e = q.pop_front();
                    chk("digit_valid", bus.digit_valid, e.dv);
                    chk("invalid", bus.invalid, e.inv);
                    chk("blank", bus.blank, e.blk);
                    chk("digit", bus.digit, e.digit);
                    chk("seq_err", bus.seq_err, e.seq);
                    chk("err_cnt", bus.err_cnt, e.err);
                    chk("locked", bus.locked, e.locked);
                end else begin
                    chk("unexpected_event", 1, 0);
                end
            end
            while (q.size() > 0 && q[0].t < cyc) begin
                chk("missed_event_at", cyc, q[0].t);
                void'(q.pop_front());
            end
            blank_prev = (bus.blank === 1'b1);
        end
    end

    initial begin : stim
        logic [6:0] p;
        int         r;
        bus.seg  = 7'h7F;
        prev_seg = 7'h7F;
        m_last = 0; m_err = 0; m_locked = 0; m_blank = 0;

        // reset with blank held: blank accepted S edges later
        do_reset(10);

        // full count 0..9,0
        for (int i = 0; i <= 10; i++) drive(font[i % 10], 10);

        // 1,2,3 then skip to 5 (sequence error), then 6
        drive(font[1], 10); drive(font[2], 10); drive(font[3], 10);
        drive(font[5], 10); drive(font[6], 10);

        // glitch on 4 discarded, 2 accepted once
        drive(font[4], 2);
        drive(font[2], 10);

        // undecodable pattern
        drive(7'h55, 10);

        // climb to 7, blank resync, then 2 without sequence error
        for (int i = 3; i <= 7; i++) drive(font[i], 10);
        drive(7'h7F, 10);
        drive(font[2], 10);

        // reset while 3 is partway through qualification
        drive(font[3], 3);
        do_reset(12);

        // randomized segments
        for (int i = 0; i < 300; i++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 30)      p = font[(m_last + 1) % 10];
                else if (r < 60) p = font[$urandom_range(0, 9)];
                else if (r < 75) p = 7'h7F;
                else             p = 7'($urandom_range(0, 127));
            end while (p == prev_seg);
            drive(p, $urandom_range(1, 9));
        end

        // drive the error counter into saturation
        for (int i = 0; i < 300; i++) begin
            drive(7'h55, S);
            drive(font[$urandom_range(0, 9)], S);
        end
        drive(7'h7F, 12);
        chk("err_cnt_saturated", bus.err_cnt, ERR_MAX);

        repeat (10) @(negedge clk);
        chk("queue_empty_at_end", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
